// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation codes, FSM states and iteration count for the multiply/divide unit
package muldiv_pkg;
  localparam int MULDIV_ITER = 32;
  typedef enum logic [2:0] {
    MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
    MTHI = 3'd4, MTLO = 3'd5, RSV6 = 3'd6, RSV7 = 3'd7
  } muldiv_op_t;
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} muldiv_state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the CPU and the multiply/divide unit
interface muldiv_if;
  import muldiv_pkg::*;
  logic start;
  muldiv_op_t op;
  logic [31:0] a;
  logic [31:0] b;
  logic abort;
  logic busy;
  logic done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, abort, input busy, done, hi, lo);
  modport slave (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide owning HI/LO
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic clk,
  input logic reset_n,
  muldiv_if.slave m
);
  muldiv_state_t st, nxt;
  logic [1:0] opr;
  logic [31:0] ra, rb, hi_r, lo_r;
  logic [63:0] acc, acc_nx, prod;
  logic [4:0] cnt;
  logic neg_q, neg_r, done_r;
  logic mul, sgn, ge, dz;
  logic [32:0] add_a, add_b, sum;
  logic [31:0] quo, rem;
  assign mul = !opr[1];
  assign sgn = !opr[0];
  assign m.busy = st != IDLE;
  assign m.done = done_r;
  assign m.hi = hi_r;
  assign m.lo = lo_r;
  // one shared 33-bit adder: add for shift-add multiply, subtract for restoring divide
  always_comb begin
    nxt = (st != IDLE && m.abort) ? IDLE :
          st == IDLE ? ((m.start && !m.op[2]) ? PREP : IDLE) :
          st == PREP ? CALC :
          st == CALC ? ((cnt == 5'(MULDIV_ITER - 1)) ? FIX : CALC) : IDLE;
    add_a = mul ? {1'b0, acc[63:32]} : {acc[63:32], ra[5'd31 - cnt]};
    add_b = mul ? {1'b0, rb[cnt] ? ra : 32'd0} : {1'b1, ~rb};
    sum = add_a + add_b + {32'd0, !mul};
    ge = !sum[32];
    acc_nx = mul ? {sum, acc[31:1]} : {ge ? sum[31:0] : add_a[31:0], acc[30:0], ge};
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[31:0] : acc[31:0];
    rem = neg_r ? -acc[63:32] : acc[63:32];
    dz = rb == 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      opr <= 2'd0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done_r <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      st <= nxt;
      done_r <= 1'b0;
      if (st == IDLE && m.start) begin
        if (m.op == MTHI) hi_r <= m.a;
        if (m.op == MTLO) lo_r <= m.a;
        opr <= m.op[1:0];
        ra <= m.a;
        rb <= m.b;
      end
      if (st == PREP) begin
        ra <= (sgn && ra[31]) ? -ra : ra;
        rb <= (sgn && rb[31]) ? -rb : rb;
        neg_q <= sgn && (ra[31] ^ rb[31]);
        neg_r <= sgn && ra[31];
        acc <= '0;
        cnt <= '0;
      end
      if (st == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 5'd1;
      end
      if (st == FIX && !m.abort) begin
        done_r <= 1'b1;
        if (mul) {hi_r, lo_r} <= prod;
        else if (dz) begin
          hi_r <= neg_r ? -ra : ra;
          lo_r <= '1;
        end else begin
          hi_r <= rem;
          lo_r <= quo;
        end
      end
    end
  end
endmodule
